// File: rtl/ysyx_24100006_lsu_pkg.sv
// Shared encodings for the load/store unit: op, size, exception and FSM state
// codes plus the AXI OKAY response value.
package ysyx_24100006_lsu_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2,
        OP_RSVD  = 2'd3
    } lsu_op_e;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'd0,
        EXC_MISALIGN = 2'd1,
        EXC_BUS      = 2'd2,
        EXC_TIMEOUT  = 2'd3
    } lsu_exc_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR      = 3'd3,
        WR_RESP = 3'd4,
        RESP    = 3'd5
    } lsu_state_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_24100006_lsu_align.sv
// Byte-lane alignment: misalignment check, write strobe/shift, read shift
// with sign/zero extension. Purely combinational.
module ysyx_24100006_lsu_align
    import ysyx_24100006_lsu_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
    input  lsu_size_e           size,
    input  logic [OFF_W-1:0]    off,
    input  logic                sext,
    input  logic [DATA_W-1:0]   wdata_in,
    input  logic [DATA_W-1:0]   rdata_in,
    output logic                misaligned,
    output logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   wdata_out,
    output logic [DATA_W-1:0]   rdata_out
);

    logic [OFF_W:0]    nbytes;
    logic [DATA_W-1:0] shifted;
    logic              sign;

    always_comb begin
        shifted = rdata_in >> {off, 3'b000};
        case (size)
            SZ_BYTE: begin
                nbytes     = (OFF_W + 1)'(1);
                sign       = shifted[7];
                misaligned = 1'b0;
            end
            SZ_HALF: begin
                nbytes     = (OFF_W + 1)'(2);
                sign       = shifted[15];
                misaligned = off[0];
            end
            SZ_WORD: begin
                nbytes     = (OFF_W + 1)'(4);
                sign       = shifted[31];
                misaligned = |off[1:0];
            end
            default: begin
                nbytes     = (OFF_W + 1)'(DATA_W / 8);
                sign       = shifted[DATA_W-1];
                misaligned = (DATA_W == 32) || (|off);
            end
        endcase

        for (int unsigned i = 0; i < DATA_W; i++) begin
            rdata_out[i] = (i < 32'(nbytes) * 8) ? shifted[i] : (sext & sign);
        end
        for (int unsigned b = 0; b < DATA_W / 8; b++) begin
            wstrb[b] = (b >= 32'(off)) && (b < 32'(off) + 32'(nbytes));
        end
        wdata_out = wdata_in << {off, 3'b000};
    end

endmodule

// File: rtl/ysyx_24100006_lsu.sv
// Load/store unit between EXEU and WBU driving an AXI master (AR/R/AW/W/B).
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN.
module ysyx_24100006_lsu
    import ysyx_24100006_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned PAYLOAD_W   = 64,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [ADDR_W-1:0]    in_addr,
    input  logic [DATA_W-1:0]    in_wdata,
    input  logic [1:0]           in_size,
    input  logic                 in_sext,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_rdata,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [1:0]           out_exc,
    output logic [ADDR_W-1:0]    axi_araddr,
    output logic [2:0]           axi_arsize,
    output logic                 axi_arvalid,
    input  logic                 axi_arready,
    input  logic [DATA_W-1:0]    axi_rdata,
    input  logic [1:0]           axi_rresp,
    input  logic                 axi_rvalid,
    output logic                 axi_rready,
    output logic [ADDR_W-1:0]    axi_awaddr,
    output logic [2:0]           axi_awsize,
    output logic                 axi_awvalid,
    input  logic                 axi_awready,
    output logic [DATA_W-1:0]    axi_wdata,
    output logic [DATA_W/8-1:0]  axi_wstrb,
    output logic                 axi_wvalid,
    input  logic                 axi_wready,
    input  logic [1:0]           axi_bresp,
    input  logic                 axi_bvalid,
    output logic                 axi_bready
);

    localparam int unsigned OFF_W = $clog2(DATA_W / 8);

    lsu_state_e           state_q,   state_d;
    logic [ADDR_W-1:0]    addr_q,    addr_d;
    logic [DATA_W-1:0]    wdata_q,   wdata_d;
    lsu_size_e            size_q,    size_d;
    logic                 sext_q,    sext_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic                 aw_done_q, aw_done_d;
    logic                 w_done_q,  w_done_d;
    logic [DATA_W-1:0]    rdata_q,   rdata_d;
    lsu_exc_e             exc_q,     exc_d;

    lsu_op_e           op_in;
    logic              accept;
    lsu_size_e         size_sel;
    logic [OFF_W-1:0]  off_sel;
    logic              misaligned;
    logic [DATA_W-1:0] align_rdata;

    assign op_in    = lsu_op_e'(in_op);
    assign in_ready = (state_q == IDLE) || ((state_q == RESP) && out_ready);
    assign accept   = in_valid && in_ready;

    // One aligner serves both paths: it checks the incoming op while accepting
    // and shapes bus data from the latched op otherwise (never both at once).
    assign size_sel = in_ready ? lsu_size_e'(in_size)     : size_q;
    assign off_sel  = in_ready ? in_addr[OFF_W-1:0]       : addr_q[OFF_W-1:0];

    ysyx_24100006_lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .size       (size_sel),
        .off        (off_sel),
        .sext       (sext_q),
        .wdata_in   (wdata_q),
        .rdata_in   (axi_rdata),
        .misaligned (misaligned),
        .wstrb      (axi_wstrb),
        .wdata_out  (axi_wdata),
        .rdata_out  (align_rdata)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             bus_state;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        sext_d    = sext_q;
        payload_d = payload_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        exc_d     = exc_q;

        case (state_q)
            RD_ADDR: if (axi_arready) state_d = RD_DATA;
            RD_DATA: begin
                if (axi_rvalid) begin
                    state_d = RESP;
                    if (axi_rresp != AXI_RESP_OKAY) begin
                        exc_d   = EXC_BUS;
                        rdata_d = '0;
                    end else begin
                        rdata_d = align_rdata;
                    end
                end
            end
            WR: begin
                aw_done_d = aw_done_q || axi_awready;
                w_done_d  = w_done_q  || axi_wready;
                if (aw_done_d && w_done_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (axi_bvalid) begin
                    state_d = RESP;
                    if (axi_bresp != AXI_RESP_OKAY) exc_d = EXC_BUS;
                end
            end
            RESP:    if (out_ready) state_d = IDLE;
            default: ;
        endcase

        if (accept) begin
            addr_d    = in_addr;
            wdata_d   = in_wdata;
            size_d    = lsu_size_e'(in_size);
            sext_d    = in_sext;
            payload_d = in_payload;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            rdata_d   = '0;
            exc_d     = EXC_NONE;
            case (op_in)
                OP_LOAD, OP_STORE: begin
                    if (misaligned) begin
                        state_d = RESP;
                        exc_d   = EXC_MISALIGN;
                    end else begin
                        state_d = (op_in == OP_LOAD) ? RD_ADDR : WR;
                    end
                end
                default: state_d = RESP;
            endcase
        end

`ifdef LSU_TIMEOUT_EN
        bus_state = (state_q == RD_ADDR) || (state_q == RD_DATA) ||
                    (state_q == WR)      || (state_q == WR_RESP);
        // A handshake completing on the final cycle still wins over the watchdog.
        if (bus_state && (state_d == state_q) &&
            (tmo_q == TMO_W'(TIMEOUT_CYC - 1))) begin
            state_d = RESP;
            exc_d   = EXC_TIMEOUT;
            rdata_d = '0;
        end
        if (state_d != state_q)  tmo_d = '0;
        else if (bus_state)      tmo_d = tmo_q + TMO_W'(1);
        else                     tmo_d = '0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= SZ_BYTE;
            sext_q    <= 1'b0;
            payload_q <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            exc_q     <= EXC_NONE;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            sext_q    <= sext_d;
            payload_q <= payload_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            exc_q     <= exc_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`else
`endif

    assign axi_araddr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign axi_awaddr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign axi_arsize  = {1'b0, size_q};
    assign axi_awsize  = {1'b0, size_q};
    assign axi_arvalid = (state_q == RD_ADDR);
    assign axi_rready  = (state_q == RD_DATA);
    assign axi_awvalid = (state_q == WR) && !aw_done_q;
    assign axi_wvalid  = (state_q == WR) && !w_done_q;
    assign axi_bready  = (state_q == WR_RESP);

    assign out_valid   = (state_q == RESP);
    assign out_rdata   = rdata_q;
    assign out_payload = payload_q;
    assign out_exc     = exc_q;

endmodule

// File: tb/tb_ysyx_24100006_lsu.sv
// Directed bench for ysyx_24100006_lsu with a small reactive AXI slave.
module tb_ysyx_24100006_lsu;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [1:0]  in_size;
    logic        in_sext;
    logic [63:0] in_payload;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic [63:0] out_payload;
    logic [1:0]  out_exc;
    logic [31:0] axi_araddr;
    logic [2:0]  axi_arsize;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_awaddr;
    logic [2:0]  axi_awsize;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;

    int errors = 0;
    int checks = 0;

    // slave knobs
    logic        ar_en;
    logic [31:0] rd_val;
    logic [1:0]  r_resp;
    logic [1:0]  b_resp;
    int unsigned w_delay;

    logic        aw_seen, w_seen;
    int unsigned w_cnt;
    int unsigned ar_cnt = 0;
    int unsigned out_cnt = 0;

    ysyx_24100006_lsu #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .PAYLOAD_W   (64),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_addr     (in_addr),
        .in_wdata    (in_wdata),
        .in_size     (in_size),
        .in_sext     (in_sext),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rdata   (out_rdata),
        .out_payload (out_payload),
        .out_exc     (out_exc),
        .axi_araddr  (axi_araddr),
        .axi_arsize  (axi_arsize),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .axi_awaddr  (axi_awaddr),
        .axi_awsize  (axi_awsize),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait slave: response is registered on the request handshake edge.
    assign axi_arready = ar_en;
    assign axi_awready = axi_awvalid;
    assign axi_wready  = axi_wvalid && (w_cnt >= w_delay);
    assign axi_rdata   = rd_val;
    assign axi_rresp   = r_resp;
    assign axi_bresp   = b_resp;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            axi_rvalid <= 1'b0;
            axi_bvalid <= 1'b0;
            aw_seen    <= 1'b0;
            w_seen     <= 1'b0;
            w_cnt      <= 0;
        end else begin
            if (axi_rvalid && axi_rready) axi_rvalid <= 1'b0;
            if (axi_arvalid && axi_arready) axi_rvalid <= 1'b1;
            if (axi_bvalid && axi_bready) axi_bvalid <= 1'b0;
            if ((aw_seen || (axi_awvalid && axi_awready)) &&
                (w_seen || (axi_wvalid && axi_wready))) begin
                axi_bvalid <= 1'b1;
                aw_seen    <= 1'b0;
                w_seen     <= 1'b0;
            end else begin
                aw_seen <= aw_seen || (axi_awvalid && axi_awready);
                w_seen  <= w_seen  || (axi_wvalid && axi_wready);
            end
            if (!axi_wvalid || axi_wready) w_cnt <= 0;
            else                           w_cnt <= w_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (axi_arvalid) ar_cnt <= ar_cnt + 1;
        if (out_valid && out_ready) out_cnt <= out_cnt + 1;
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] size, input logic sext, input logic [63:0] pl);
        int unsigned n = 0;
        in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wd;
        in_size = size; in_sext = sext; in_payload = pl;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #3;
        checks++;
        if ({axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready, out_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_valids: got %b expected 000000",
                     {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready, out_valid});
        end
        checks++;
        if (out_exc !== 2'd0 || out_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got exc=%0d rdata=%h expected exc=0 rdata=00000000", out_exc, out_rdata);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        idle(1);
    endtask

    task automatic test_load_word;
        int lat;
        rd_val = 32'hDEAD_BEEF;
        issue(2'b01, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 64'h1111);
        checks++;
        if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h8000_0004 || axi_arsize !== 3'd2) begin
            errors++;
            $display("FAIL lw_ar: got v=%b addr=%h size=%0d expected v=1 addr=80000004 size=2",
                     axi_arvalid, axi_araddr, axi_arsize);
        end
        wait_out(lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL lw_latency: got %0d expected 3", lat);
        end
        checks++;
        if (out_rdata !== 32'hDEAD_BEEF || out_exc !== 2'd0 || out_payload !== 64'h1111) begin
            errors++;
            $display("FAIL lw_result: got rdata=%h exc=%0d pl=%h expected DEADBEEF 0 1111",
                     out_rdata, out_exc, out_payload);
        end
        idle(2);
    endtask

    task automatic test_store_byte;
        int lat;
        logic [31:0] wd;
        issue(2'b10, 32'h8000_0003, 32'h0000_00A5, 2'd0, 1'b0, 64'h2222);
        wd = axi_wdata;
        checks++;
        if (axi_awaddr !== 32'h8000_0000 || axi_wstrb !== 4'b1000 || wd[31:24] !== 8'hA5) begin
            errors++;
            $display("FAIL sb_lane: got addr=%h strb=%b wd=%h expected 80000000 1000 A5xxxxxx",
                     axi_awaddr, axi_wstrb, wd);
        end
        wait_out(lat);
        checks++;
        if (lat !== 3 || out_exc !== 2'd0 || out_rdata !== 32'd0) begin
            errors++;
            $display("FAIL sb_result: got lat=%0d exc=%0d rdata=%h expected 3 0 00000000",
                     lat, out_exc, out_rdata);
        end
        idle(2);
    endtask

    task automatic test_store_wdelay;
        int lat;
        int unsigned snap;
        w_delay = 4;
        snap = out_cnt;
        issue(2'b10, 32'h8000_0003, 32'h0000_00A5, 2'd0, 1'b0, 64'h3333);
        wait_out(lat);
        checks++;
        if (lat !== 7 || out_exc !== 2'd0) begin
            errors++;
            $display("FAIL sb_wdelay: got lat=%0d exc=%0d expected 7 0", lat, out_exc);
        end
        idle(6);
        checks++;
        if (out_cnt - snap !== 1) begin
            errors++;
            $display("FAIL sb_wdelay_count: got %0d expected 1", out_cnt - snap);
        end
        w_delay = 0;
    endtask

    task automatic test_load_half;
        int lat;
        rd_val    = 32'h8001_0000;
        out_ready = 1'b0;
        issue(2'b01, 32'h8000_0002, 32'h0, 2'd1, 1'b1, 64'h4444);
        wait_out(lat);
        checks++;
        if (out_rdata !== 32'hFFFF_8001) begin
            errors++;
            $display("FAIL lh_sext: got %h expected FFFF8001", out_rdata);
        end
        idle(2);
        checks++;
        if (out_valid !== 1'b1 || out_rdata !== 32'hFFFF_8001 || out_payload !== 64'h4444) begin
            errors++;
            $display("FAIL lh_hold: got v=%b rdata=%h pl=%h expected 1 FFFF8001 4444",
                     out_valid, out_rdata, out_payload);
        end
        out_ready = 1'b1;
        idle(1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lh_retire: got %b expected 0", out_valid);
        end
        issue(2'b01, 32'h8000_0002, 32'h0, 2'd1, 1'b0, 64'h4445);
        wait_out(lat);
        checks++;
        if (out_rdata !== 32'h0000_8001) begin
            errors++;
            $display("FAIL lh_zext: got %h expected 00008001", out_rdata);
        end
        idle(2);
    endtask

    task automatic test_misaligned;
        int lat;
        int unsigned snap;
        snap = ar_cnt;
        issue(2'b01, 32'h8000_0001, 32'h0, 2'd2, 1'b0, 64'h5555);
        wait_out(lat);
        checks++;
        if (lat !== 1 || out_exc !== 2'd1) begin
            errors++;
            $display("FAIL mis_word: got lat=%0d exc=%0d expected 1 1", lat, out_exc);
        end
        idle(2);
        checks++;
        if (ar_cnt !== snap) begin
            errors++;
            $display("FAIL mis_no_ar: got %0d arvalid cycles expected 0", ar_cnt - snap);
        end
        issue(2'b01, 32'h8000_0000, 32'h0, 2'd3, 1'b0, 64'h5556);
        wait_out(lat);
        checks++;
        if (lat !== 1 || out_exc !== 2'd1) begin
            errors++;
            $display("FAIL mis_dword: got lat=%0d exc=%0d expected 1 1", lat, out_exc);
        end
        idle(2);
    endtask

    task automatic test_bus_err;
        int lat;
        b_resp = 2'b10;
        issue(2'b10, 32'h8000_0008, 32'h1234_5678, 2'd2, 1'b0, 64'h6666);
        wait_out(lat);
        checks++;
        if (lat !== 3 || out_exc !== 2'd2) begin
            errors++;
            $display("FAIL store_berr: got lat=%0d exc=%0d expected 3 2", lat, out_exc);
        end
        b_resp = 2'b00;
        idle(2);
        r_resp = 2'b10;
        rd_val = 32'hCAFE_F00D;
        issue(2'b01, 32'h8000_0008, 32'h0, 2'd2, 1'b0, 64'h6667);
        wait_out(lat);
        checks++;
        if (out_exc !== 2'd2 || out_rdata !== 32'd0) begin
            errors++;
            $display("FAIL load_rerr: got exc=%0d rdata=%h expected 2 00000000", out_exc, out_rdata);
        end
        r_resp = 2'b00;
        idle(2);
    endtask

    task automatic test_back_to_back;
        int unsigned snap;
        snap = out_cnt;
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = 2'b00; in_addr = 32'h0; in_size = 2'd0;
        in_sext = 1'b0; in_wdata = 32'h0; in_payload = 64'hA5A5;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_payload !== 64'hA5A5) begin
            errors++;
            $display("FAIL b2b_first: got v=%b pl=%h expected 1 A5A5", out_valid, out_payload);
        end
        in_payload = 64'h5A5A;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_payload !== 64'h5A5A) begin
            errors++;
            $display("FAIL b2b_second: got v=%b pl=%h expected 1 5A5A", out_valid, out_payload);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || out_cnt - snap !== 2) begin
            errors++;
            $display("FAIL b2b_count: got v=%b n=%0d expected 0 2", out_valid, out_cnt - snap);
        end
        idle(1);
    endtask

    task automatic test_reset_mid_read;
        rd_val = 32'h0BAD_0BAD;
        issue(2'b01, 32'h8000_0010, 32'h0, 2'd2, 1'b0, 64'h7777);
        @(posedge clk); #1;
        checks++;
        if (axi_rready !== 1'b1) begin
            errors++;
            $display("FAIL rst_rd_data_entry: got rready=%b expected 1", axi_rready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (axi_arvalid !== 1'b0 || axi_rready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_read: got ar=%b r=%b ov=%b expected 0 0 0",
                     axi_arvalid, axi_rready, out_valid);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_release: got in_ready=%b ov=%b expected 1 0", in_ready, out_valid);
        end
        idle(2);
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout;
        int cnt = 0;
        ar_en = 1'b0;
        issue(2'b01, 32'h8000_0020, 32'h0, 2'd2, 1'b0, 64'h8888);
        while (axi_arvalid && cnt < 50) begin
            cnt++;
            @(posedge clk); #1;
        end
        checks++;
        if (cnt !== 8) begin
            errors++;
            $display("FAIL tmo_cycles: got %0d expected 8", cnt);
        end
        checks++;
        if (out_valid !== 1'b1 || out_exc !== 2'd3) begin
            errors++;
            $display("FAIL tmo_exc: got v=%b exc=%0d expected 1 3", out_valid, out_exc);
        end
        ar_en = 1'b1;
        idle(2);
    endtask
`endif

    initial begin
        in_valid = 1'b0; in_op = 2'b00; in_addr = '0; in_wdata = '0;
        in_size = 2'd0; in_sext = 1'b0; in_payload = '0; out_ready = 1'b1;
        ar_en = 1'b1; rd_val = '0; r_resp = 2'b00; b_resp = 2'b00; w_delay = 0;
        test_reset;
        test_load_word;
        test_store_byte;
        test_store_wdelay;
        test_load_half;
        test_misaligned;
        test_bus_err;
        test_back_to_back;
        test_reset_mid_read;
`ifdef LSU_TIMEOUT_EN
        test_timeout;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
